// File: rtl/ascon_round_unit.sv
// ascon_round_unit
// One ASCON permutation round per clock with a built-in round-index counter.
//
// Ports
//   clk         rising-edge clock
//   RST         asynchronous, active-high reset
//   rcmode[1:0] 0 = hold, 1 = advance, 2 = load rcinit, 3 = hold (reserved)
//   rcinit[3:0] starting round index used on a load (0 for p12, 6 for p6)
//   Xi0..Xi4    64-bit state words presented for the next round
//   Xo0..Xo4    registered state after the most recent round
//   rc_idx      registered round-index counter (index of the next round)
//   round_done  registered one-cycle pulse after the round with index 11
//
// The controller owns the round count; there is no handshake. A load applies
// the round at rcinit in the same cycle, so a load followed by (11 - s)
// advances applies rounds s..11.

module ascon_round_unit (
  input  logic        clk,
  input  logic        RST,
  input  logic [1:0]  rcmode,
  input  logic [3:0]  rcinit,
  input  logic [63:0] Xi0,
  input  logic [63:0] Xi1,
  input  logic [63:0] Xi2,
  input  logic [63:0] Xi3,
  input  logic [63:0] Xi4,
  output logic [63:0] Xo0,
  output logic [63:0] Xo1,
  output logic [63:0] Xo2,
  output logic [63:0] Xo3,
  output logic [63:0] Xo4,
  output logic [3:0]  rc_idx,
  output logic        round_done
);

  // 64-bit right rotation by a nonzero amount.
  function automatic logic [63:0] ror64(input logic [63:0] v, input logic [5:0] n);
    return (v >> n) | (v << (7'd64 - {1'b0, n}));
  endfunction

  // One full ASCON round: constant addition, 5-bit S-box layer, linear layer.
  // State is packed as {x4, x3, x2, x1, x0}.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[63:0];
    x1 = s[127:64];
    x2 = s[191:128];
    x3 = s[255:192];
    x4 = s[319:256];
    // constant addition
    x2 = x2 ^ {56'd0, c};
    // substitution layer (bitsliced S-box)
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    // every t uses the pre-chi values, so compute all before updating x
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // linear diffusion layer
    x0 = x0 ^ ror64(x0, 6'd19) ^ ror64(x0, 6'd28);
    x1 = x1 ^ ror64(x1, 6'd61) ^ ror64(x1, 6'd39);
    x2 = x2 ^ ror64(x2, 6'd1)  ^ ror64(x2, 6'd6);
    x3 = x3 ^ ror64(x3, 6'd10) ^ ror64(x3, 6'd17);
    x4 = x4 ^ ror64(x4, 6'd7)  ^ ror64(x4, 6'd41);
    return {x4, x3, x2, x1, x0};
  endfunction

  logic [319:0] state_r;
  logic [3:0]   rc_idx_r;
  logic         round_done_r;

  logic [3:0]   idx_s;
  logic         active_s;
  logic [7:0]   rc_s;
  logic [319:0] state_in_s;
  logic [319:0] round_s;

  // Decode the control mode: pick the effective index and whether a round runs.
  always_comb begin
    idx_s    = rc_idx_r;
    active_s = 1'b0;
    case (rcmode)
      2'd1: begin
        idx_s    = rc_idx_r;
        active_s = 1'b1;
      end
      2'd2: begin
        idx_s    = rcinit;
        active_s = 1'b1;
      end
      default: begin
        idx_s    = rc_idx_r;
        active_s = 1'b0;
      end
    endcase
  end

  // Round constant: high nibble is the complement of the index, so indices
  // 12..15 reached after a wrap still produce a well-defined constant.
  assign rc_s       = {4'hF - idx_s, idx_s};
  assign state_in_s = {Xi4, Xi3, Xi2, Xi1, Xi0};
  assign round_s    = ascon_round(state_in_s, rc_s);

  // State, counter and done-pulse registers; hold whenever no round runs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r      <= 320'd0;
      rc_idx_r     <= 4'd0;
      round_done_r <= 1'b0;
    end else begin
      round_done_r <= active_s && (idx_s == 4'd11);
      if (active_s) begin
        state_r  <= round_s;
        rc_idx_r <= idx_s + 4'd1;
      end
    end
  end

  assign Xo0        = state_r[63:0];
  assign Xo1        = state_r[127:64];
  assign Xo2        = state_r[191:128];
  assign Xo3        = state_r[255:192];
  assign Xo4        = state_r[319:256];
  assign rc_idx     = rc_idx_r;
  assign round_done = round_done_r;

endmodule

// File: tb/tb_ascon_round_unit.sv
// Self-checking bench for ascon_round_unit: randomized stimulus compared every
// cycle against a loop-based ASCON round model, plus directed permutation runs.

module tb_ascon_round_unit;

  logic        clk;
  logic        RST;
  logic [1:0]  rcmode;
  logic [3:0]  rcinit;
  logic [63:0] xi [5];
  logic [63:0] xo [5];
  logic [3:0]  rc_idx;
  logic        round_done;

  int n_cmp;
  int n_bad;
  int done_cnt;

  // reference model state
  logic [319:0] m_st;
  logic [3:0]   m_idx;
  logic         m_done;

  ascon_round_unit dut (
    .clk        (clk),
    .RST        (RST),
    .rcmode     (rcmode),
    .rcinit     (rcinit),
    .Xi0        (xi[0]),
    .Xi1        (xi[1]),
    .Xi2        (xi[2]),
    .Xi3        (xi[3]),
    .Xi4        (xi[4]),
    .Xo0        (xo[0]),
    .Xo1        (xo[1]),
    .Xo2        (xo[2]),
    .Xo3        (xo[3]),
    .Xo4        (xo[4]),
    .rc_idx     (rc_idx),
    .round_done (round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Behavioural ASCON round written from the textual rules with index loops.
  function automatic logic [319:0] model_round(input logic [319:0] st, input int idx);
    logic [63:0] x [5];
    logic [63:0] t [5];
    int ra [5];
    int rb [5];
    int c;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) x[i] = st[64*i +: 64];
    c = (15 - idx) * 16 + idx;
    x[2] = x[2] ^ 64'(c);
    x[0] ^= x[4];
    x[4] ^= x[3];
    x[2] ^= x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
    x[1] ^= x[0];
    x[0] ^= x[4];
    x[3] ^= x[2];
    x[2] = ~x[2];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ rotr(x[i], ra[i]) ^ rotr(x[i], rb[i]);
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  // Golden permutation p(12 - start): rounds start..11.
  function automatic logic [319:0] golden_perm(input logic [319:0] st, input int start);
    logic [319:0] s;
    s = st;
    for (int r = start; r < 12; r++) s = model_round(s, r);
    return s;
  endfunction

  task automatic check_outputs(input string ctx);
    for (int i = 0; i < 5; i++) check($sformatf("%s Xo%0d", ctx, i), xo[i], m_st[64*i +: 64]);
    check({ctx, " rc_idx"}, {60'd0, rc_idx}, {60'd0, m_idx});
    check({ctx, " round_done"}, {63'd0, round_done}, {63'd0, m_done});
  endtask

  // Drive one cycle using the current xi, advance the model, check after the edge.
  task automatic run_cycle(input string ctx, input logic [1:0] mode, input logic [3:0] init);
    int idx;
    logic [319:0] cur;
    rcmode = mode;
    rcinit = init;
    cur = {xi[4], xi[3], xi[2], xi[1], xi[0]};
    idx = (mode == 2'd2) ? int'(init) : int'(m_idx);
    if (mode == 2'd1 || mode == 2'd2) begin
      m_st   = model_round(cur, idx);
      m_done = (idx == 11);
      m_idx  = 4'((idx + 1) % 16);
    end else begin
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
    if (round_done) done_cnt++;
    check_outputs(ctx);
  endtask

  task automatic xi_random();
    for (int i = 0; i < 5; i++) xi[i] = {$urandom, $urandom};
  endtask

  task automatic xi_from_model();
    for (int i = 0; i < 5; i++) xi[i] = m_st[64*i +: 64];
  endtask

  task automatic xi_from_state(input logic [319:0] s);
    for (int i = 0; i < 5; i++) xi[i] = s[64*i +: 64];
  endtask

  task automatic check_state(input string ctx, input logic [319:0] s);
    for (int i = 0; i < 5; i++) check($sformatf("%s Xo%0d", ctx, i), xo[i], s[64*i +: 64]);
  endtask

  task automatic check_zero(input string ctx);
    for (int i = 0; i < 5; i++) check($sformatf("%s Xo%0d", ctx, i), xo[i], 64'd0);
    check({ctx, " rc_idx"}, {60'd0, rc_idx}, 64'd0);
    check({ctx, " round_done"}, {63'd0, round_done}, 64'd0);
  endtask

  // Run load at start followed by (11 - start) advances fed back from the model.
  task automatic run_perm(input string ctx, input logic [319:0] s0, input int start);
    logic [319:0] gold;
    gold = golden_perm(s0, start);
    done_cnt = 0;
    xi_from_state(s0);
    run_cycle({ctx, " load"}, 2'd2, 4'(start));
    for (int r = start + 1; r < 12; r++) begin
      xi_from_model();
      run_cycle({ctx, " adv"}, 2'd1, 4'($urandom_range(0, 15)));
    end
    check_state({ctx, " golden"}, gold);
    check({ctx, " done_count"}, 64'(done_cnt), 64'd1);
    check({ctx, " final_idx"}, {60'd0, rc_idx}, 64'd12);
  endtask

  initial begin
    logic [319:0] s0;
    logic [319:0] held;
    logic [319:0] gold;
    n_cmp    = 0;
    n_bad    = 0;
    done_cnt = 0;
    m_st     = 320'd0;
    m_idx    = 4'd0;
    m_done   = 1'b0;
    rcmode   = 2'd0;
    rcinit   = 4'd0;
    for (int i = 0; i < 5; i++) xi[i] = 64'd0;

    // reset state, asynchronous and independent of clk
    RST = 1'b1;
    #3;
    check_zero("reset");
    rcmode = 2'd2;
    xi_random();
    @(posedge clk);
    #1;
    check_zero("reset_edge");
    #2;
    RST = 1'b0;

    // zero-state round with known constants
    for (int i = 0; i < 5; i++) xi[i] = 64'd0;
    run_cycle("zero", 2'd2, 4'd0);
    check("zero_const Xo0", xo[0], 64'h001E0F00000000F0);
    check("zero_const Xo3", xo[3], 64'h3C780000000000F0);
    check("zero_const Xo4", xo[4], 64'd0);
    check("zero_const rc_idx", {60'd0, rc_idx}, 64'd1);

    // hold with random Xi
    held = m_st;
    for (int k = 0; k < 5; k++) begin
      xi_random();
      run_cycle("hold", (k % 2 == 0) ? 2'd0 : 2'd3, 4'($urandom_range(0, 15)));
    end
    check_state("hold_final", held);
    check("hold_final rc_idx", {60'd0, rc_idx}, 64'd1);

    // p12 on an ASCON-128 initial state
    s0 = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, 64'h80400c0600000000};
    run_perm("p12", s0, 0);

    // p6 on a random state
    s0 = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}};
    run_perm("p6", s0, 6);

    // reset mid-run after round 4 of p12
    xi_random();
    run_cycle("abort load", 2'd2, 4'd0);
    for (int r = 0; r < 3; r++) begin
      xi_from_model();
      run_cycle("abort adv", 2'd1, 4'd0);
    end
    #2;
    RST = 1'b1;
    #1;
    m_st   = 320'd0;
    m_idx  = 4'd0;
    m_done = 1'b0;
    check_zero("abort async");
    @(posedge clk);
    #1;
    check_zero("abort held");
    #2;
    RST = 1'b0;
    xi_random();
    run_cycle("abort idle", 2'd0, 4'd0);
    s0 = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}};
    run_perm("restart_p6", s0, 6);

    // wrap from 15 to 0
    xi_random();
    s0 = {xi[4], xi[3], xi[2], xi[1], xi[0]};
    gold = model_round(model_round(s0, 15), 0);
    run_cycle("wrap load", 2'd2, 4'd15);
    check("wrap load rc_idx", {60'd0, rc_idx}, 64'd0);
    xi_from_model();
    run_cycle("wrap adv", 2'd1, 4'd3);
    check_state("wrap golden", gold);
    check("wrap rc_idx", {60'd0, rc_idx}, 64'd1);

    // back-to-back loads: each applies its own rcinit
    for (int k = 0; k < 4; k++) begin
      xi_random();
      run_cycle("b2b", 2'd2, (k == 3) ? 4'd11 : 4'($urandom_range(0, 15)));
    end

    // random mix of modes, indices and states
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 0) xi_random();
      else xi_from_model();
      run_cycle("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
